// File: rtl/sump_seq_pkg.sv
// ---------------------------------------------------------------------------
// sump_seq_pkg
// Shared types and constants for the SUMP script sequencer.
//   kind_e   : script entry kind (SHORT, LONG, WAIT, END)
//   entry_t  : one 42-bit script entry {kind, opcode, value}
//   state_e  : sequencer FSM states
//   OP_*     : SUMP command opcodes used when building scripts
//   payload_byte() : picks byte <idx> of a long-command value, LSB first
// ---------------------------------------------------------------------------
package sump_seq_pkg;

    localparam int ENTRY_W = 42;

    typedef enum logic [1:0] {
        KIND_SHORT = 2'd0,
        KIND_LONG  = 2'd1,
        KIND_WAIT  = 2'd2,
        KIND_END   = 2'd3
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [7:0]  opcode;
        logic [31:0] value;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_DR = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_FINISH  = 3'd6
    } state_e;

    localparam logic [7:0] OP_RESET     = 8'h00;
    localparam logic [7:0] OP_RUN       = 8'h01;
    localparam logic [7:0] OP_ID        = 8'h02;
    localparam logic [7:0] OP_META      = 8'h04;
    localparam logic [7:0] OP_XOFF      = 8'h05;
    localparam logic [7:0] OP_DIV       = 8'h80;
    localparam logic [7:0] OP_CNT       = 8'h81;
    localparam logic [7:0] OP_FLAGS     = 8'h82;
    localparam logic [7:0] OP_TRIG_MASK = 8'hC0;
    localparam logic [7:0] OP_TRIG_VAL  = 8'hC1;
    localparam logic [7:0] OP_TRIG_CFG  = 8'hC2;

    // Long-command payload goes out least-significant byte first.
    function automatic logic [7:0] payload_byte(input logic [31:0] value,
                                                input logic [1:0]  idx);
        return value[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level.
//   clock   in  : destination clock
//   reset_n in  : asynchronous active-low reset (output resets low)
//   d       in  : asynchronous input level
//   q       out : synchronised level, two clock cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sump_script_sequencer.sv
// ---------------------------------------------------------------------------
// sump_script_sequencer
// On-chip SUMP host. Replays a command script (short/long commands and
// wait-for-dataReady drains) into a byte-level full-duplex SPI engine and
// forwards every MISO byte that comes back.
//
// Parameters
//   SCRIPT_AW  : script address width (depth 2**SCRIPT_AW)
//   LONG_BYTES : payload bytes per long command, LSB first (1..4)
//   TIMEOUT_W  : WAIT timeout counter width (timeout 2**TIMEOUT_W-1 cycles)
//   DRAIN_OP   : filler byte sent while draining
//
// Ports
//   clock, reset_n        : clock, asynchronous active-low reset
//   start, abort          : run script from address 0 / stop at byte boundary
//   scr_addr, scr_data    : script read port, data valid 1 cycle after addr
//   tx_valid/ready/byte   : byte handshake towards the SPI engine
//   rx_valid, rx_byte     : completed exchange from the SPI engine
//   data_ready            : asynchronous target dataReady
//   resp_valid/byte/drain : forwarded MISO byte, drain tag
//   busy, done, error     : running, finished pulse, sticky WAIT timeout
// ---------------------------------------------------------------------------
module sump_script_sequencer
    import sump_seq_pkg::*;
#(
    parameter int         SCRIPT_AW  = 6,
    parameter int         LONG_BYTES = 4,
    parameter int         TIMEOUT_W  = 20,
    parameter logic [7:0] DRAIN_OP   = 8'h7F
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [SCRIPT_AW-1:0] scr_addr,
    input  logic [41:0]          scr_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           tx_byte,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_byte,
    input  logic                 data_ready,
    output logic                 resp_valid,
    output logic [7:0]           resp_byte,
    output logic                 resp_drain,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    state_e               state;
    logic [SCRIPT_AW-1:0] pc;
    logic [31:0]          payload;
    logic [1:0]           byte_idx;
    logic [2:0]           bytes_left;
    logic                 outstanding;
    logic                 abort_pend;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 dr_sync;
    entry_t               ent_in;
    logic                 last_entry;
    logic                 in_flight;

    sync_2ff u_dr_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (data_ready),
        .q       (dr_sync)
    );

    assign ent_in     = entry_t'(scr_data);
    assign scr_addr   = pc;
    // The script never wraps: the top entry is always the last one executed.
    assign last_entry = (pc == {SCRIPT_AW{1'b1}});
    // A byte is in flight from the moment it is presented until its
    // exchange completes; aborts wait for that boundary.
    assign in_flight  = tx_valid | outstanding;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            payload     <= '0;
            byte_idx    <= '0;
            bytes_left  <= '0;
            outstanding <= 1'b0;
            abort_pend  <= 1'b0;
            wait_cnt    <= '0;
            tx_valid    <= 1'b0;
            tx_byte     <= '0;
            resp_valid  <= 1'b0;
            resp_byte   <= '0;
            resp_drain  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            done       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // start beats a simultaneous abort here
                    if (start) begin
                        state      <= ST_FETCH;
                        pc         <= '0;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        abort_pend <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        case (ent_in.kind)
                            KIND_SHORT: begin
                                tx_byte    <= ent_in.opcode;
                                tx_valid   <= 1'b1;
                                bytes_left <= '0;
                                state      <= ST_SEND;
                            end
                            KIND_LONG: begin
                                tx_byte    <= ent_in.opcode;
                                tx_valid   <= 1'b1;
                                payload    <= ent_in.value;
                                byte_idx   <= '0;
                                bytes_left <= 3'(LONG_BYTES);
                                state      <= ST_SEND;
                            end
                            KIND_WAIT: begin
                                wait_cnt <= '0;
                                // Target already has data: skip the wait.
                                if (dr_sync) begin
                                    tx_byte  <= DRAIN_OP;
                                    tx_valid <= 1'b1;
                                    state    <= ST_DRAIN;
                                end else begin
                                    state <= ST_WAIT_DR;
                                end
                            end
                            KIND_END: begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_FINISH;
                            end
                        endcase
                    end
                end

                ST_WAIT_DR: begin
                    // Timeout takes priority so a coincident abort still
                    // leaves the error flag set.
                    if (wait_cnt == {TIMEOUT_W{1'b1}}) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (dr_sync) begin
                        tx_byte  <= DRAIN_OP;
                        tx_valid <= 1'b1;
                        state    <= ST_DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_SEND, ST_DRAIN: begin
                    if (abort && in_flight) begin
                        abort_pend <= 1'b1;
                    end
                    if (tx_valid) begin
                        // tx_byte is held untouched until the engine takes it.
                        if (tx_ready) begin
                            tx_valid    <= 1'b0;
                            outstanding <= 1'b1;
                        end
                    end else if (outstanding && rx_valid) begin
                        outstanding <= 1'b0;
                        resp_valid  <= 1'b1;
                        resp_byte   <= rx_byte;
                        resp_drain  <= (state == ST_DRAIN);
                        if (abort || abort_pend) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (state == ST_DRAIN && dr_sync) begin
                            tx_byte  <= DRAIN_OP;
                            tx_valid <= 1'b1;
                        end else if (state == ST_SEND && bytes_left != 3'd0) begin
                            tx_byte    <= payload_byte(payload, byte_idx);
                            tx_valid   <= 1'b1;
                            byte_idx   <= byte_idx + 2'd1;
                            bytes_left <= bytes_left - 3'd1;
                        end else if (last_entry) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FINISH;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end

                ST_FINISH: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
